// File: rtl/display_source_arbiter_if.sv
// Bundle between display producers and the display arbiter: requests, per-source
// digit/dp data, and the registered grant plus digits sent to the display subsystem.
interface display_source_arbiter_if #(
    parameter int unsigned NUM_SRC = 4
);
    logic [NUM_SRC-1:0]    req;
    logic [16*NUM_SRC-1:0] src_digits;
    logic [4*NUM_SRC-1:0]  src_dp;
    logic [NUM_SRC-1:0]    grant;
    logic [2:0]            owner;
    logic                  busy;
    logic [3:0]            sec_dig1;
    logic [3:0]            sec_dig2;
    logic [3:0]            min_dig1;
    logic [3:0]            min_dig2;
    logic [3:0]            decimal_point;

    modport master (
        output req, src_digits, src_dp,
        input  grant, owner, busy, sec_dig1, sec_dig2, min_dig1, min_dig2, decimal_point
    );

    modport slave (
        input  req, src_digits, src_dp,
        output grant, owner, busy, sec_dig1, sec_dig2, min_dig1, min_dig2, decimal_point
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Round-robin arbiter with minimum dwell that time-shares one 4-digit display.
// Optional macro DISPLAY_ARB_PRIORITY_EN makes source 0 pre-empt other owners.
module display_source_arbiter #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 100_000_000
) (
    input logic                     clk,
    input logic                     reset,
    display_source_arbiter_if.slave bus
);
    localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state;
    logic [2:0]           owner_q;
    logic [2:0]           rr_ptr;
    logic [CW-1:0]        cnt;

    logic [NUM_SRC-1:0]   owner_oh;
    logic                 owner_req;
    logic                 other_req;
    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   scan;
    logic                 found;
    logic [2:0]           pick;
    logic                 take;
    logic [2:0]           nxt;
    logic                 release_idle;
    logic [2:0]           sel;
    logic [15:0]          sel_dig;
    logic [3:0]           sel_dp;
    logic [2:0]           nxt_ptr;

    always_comb begin
        owner_oh  = NUM_SRC'(1) << owner_q;
        owner_req = |(bus.req & owner_oh);
        other_req = |(bus.req & ~owner_oh);

        // Rotate so the search starts at rr_ptr, then take the lowest set bit.
        dbl   = {bus.req, bus.req} >> rr_ptr;
        scan  = dbl[NUM_SRC-1:0];
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && scan[0]) begin
                found = 1'b1;
                pick  = 3'((32'(rr_ptr) + k) % NUM_SRC);
            end
            scan = scan >> 1;
        end

        take = 1'b0;
        nxt  = owner_q;
        case (state)
            IDLE: begin
                if (found) begin
                    take = 1'b1;
                    nxt  = pick;
                end
            end
            OWN: begin
                if (!owner_req || (cnt == CNT_MAX && other_req)) begin
                    if (found) begin
                        take = 1'b1;
                        nxt  = pick;
                    end
                end
            end
            default: ;
        endcase
`ifdef DISPLAY_ARB_PRIORITY_EN
        if (bus.req[0] && (state == IDLE || owner_q != 3'd0)) begin
            take = 1'b1;
            nxt  = 3'd0;
        end
`endif
        release_idle = (state == OWN) && !owner_req && !take;

        sel     = take ? nxt : owner_q;
        sel_dig = 16'(bus.src_digits >> {sel, 4'b0000});
        sel_dp  = 4'(bus.src_dp >> {sel, 2'b00});
        nxt_ptr = 3'((32'(nxt) + 32'd1) % NUM_SRC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            owner_q           <= '0;
            rr_ptr            <= '0;
            cnt               <= '0;
            bus.grant         <= '0;
            bus.sec_dig1      <= '0;
            bus.sec_dig2      <= '0;
            bus.min_dig1      <= '0;
            bus.min_dig2      <= '0;
            bus.decimal_point <= '0;
        end else begin
            if (take) begin
                state     <= OWN;
                owner_q   <= nxt;
                rr_ptr    <= nxt_ptr;
                cnt       <= '0;
                bus.grant <= NUM_SRC'(1) << nxt;
            end else if (release_idle) begin
                state     <= IDLE;
                bus.grant <= '0;
            end else if (state == OWN && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            // Digits track the (next) owner live; in IDLE they hold the last frame.
            if (take || (state == OWN && !release_idle)) begin
                {bus.min_dig2, bus.min_dig1, bus.sec_dig2, bus.sec_dig1} <= sel_dig;
                bus.decimal_point <= sel_dp;
            end
        end
    end

    assign bus.owner = owner_q;
    assign bus.busy  = (state == OWN);
endmodule

// File: tb/tb_display_source_arbiter.sv
// Self-checking bench for display_source_arbiter: directed vector table, reset and
// priority corner cases, then randomized traffic against a behavioural model.
module tb_display_source_arbiter;
    localparam int NS    = 4;
    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    display_source_arbiter_if #(.NUM_SRC(NS)) bus ();

    display_source_arbiter #(.NUM_SRC(NS), .DWELL_CYCLES(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Source data: s3=3456/1000, s2=9012/0010, s1=5678/0001, s0=1234/0100
    localparam logic [63:0] SRC_DIG = 64'h3456_9012_5678_1234;
    localparam logic [15:0] SRC_DP  = 16'b1000_0010_0001_0100;

    typedef struct {
        logic [3:0]  req;
        int          n;
        logic [3:0]  grant;
        logic        busy;
        logic [2:0]  owner;
        logic [15:0] dig;
        logic [3:0]  dp;
    } vec_t;

    vec_t vec[14];

    // Behavioural model state
    bit          m_busy;
    int          m_owner;
    int          m_held;
    int          m_next;
    logic [15:0] m_disp;
    logic [3:0]  m_dpv;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] g, input logic b,
                                 input logic [2:0] o, input logic [15:0] dig, input logic [3:0] dp);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        if (b) chk({tag, ".owner"}, 32'(bus.owner), 32'(o));
        chk({tag, ".digits"}, 32'({bus.min_dig2, bus.min_dig1, bus.sec_dig2, bus.sec_dig1}), 32'(dig));
        chk({tag, ".dp"}, 32'(bus.decimal_point), 32'(dp));
    endtask

    function automatic vec_t mk(input logic [3:0] r, input int n, input logic [3:0] g,
                                input logic b, input logic [2:0] o, input logic [15:0] d,
                                input logic [3:0] p);
        vec_t v;
        v.req = r; v.n = n; v.grant = g; v.busy = b; v.owner = o; v.dig = d; v.dp = p;
        return v;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_held = 0; m_next = 0; m_disp = '0; m_dpv = '0;
    endfunction

    // One clock of the arbitration rules, applied to the inputs present before the edge.
    function automatic void model_step(input logic [3:0] r, input logic [63:0] digs,
                                       input logic [15:0] dps);
        int  cand = -1;
        bit  others;
        bit  move;
        for (int k = 0; k < NS; k++) begin
            int i = (m_next + k) % NS;
            if (cand < 0 && r[i]) cand = i;
        end
        others = 0;
        for (int i = 0; i < NS; i++) if (i != m_owner && r[i]) others = 1;
        if (!m_busy)             move = (cand >= 0);
        else if (!r[m_owner])    move = 1;
        else                     move = (m_held >= DWELL - 1) && others;
`ifdef DISPLAY_ARB_PRIORITY_EN
        if (r[0] && (!m_busy || m_owner != 0)) begin
            move = 1;
            cand = 0;
        end
`endif
        if (move && cand >= 0) begin
            m_busy = 1; m_owner = cand; m_held = 0; m_next = (cand + 1) % NS;
        end else if (move) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_held++;
        end
        if (m_busy) begin
            m_disp = digs[16*m_owner +: 16];
            m_dpv  = dps[4*m_owner +: 4];
        end
    endfunction

    initial begin
        logic [3:0]  r;
        logic [63:0] d;
        logic [15:0] p;

        vec[0]  = mk(4'b0001, 1, 4'b0001, 1, 3'd0, 16'h1234, 4'b0100);
        vec[1]  = mk(4'b0000, 1, 4'b0000, 0, 3'd0, 16'h1234, 4'b0100);
        vec[2]  = mk(4'b0110, 1, 4'b0010, 1, 3'd1, 16'h5678, 4'b0001);
        vec[3]  = mk(4'b0110, 7, 4'b0010, 1, 3'd1, 16'h5678, 4'b0001);
        vec[4]  = mk(4'b0110, 8, 4'b0100, 1, 3'd2, 16'h9012, 4'b0010);
        vec[5]  = mk(4'b0110, 1, 4'b0010, 1, 3'd1, 16'h5678, 4'b0001);
        vec[6]  = mk(4'b0100, 1, 4'b0100, 1, 3'd2, 16'h9012, 4'b0010);
        vec[7]  = mk(4'b1100, 2, 4'b0100, 1, 3'd2, 16'h9012, 4'b0010);
        vec[8]  = mk(4'b1000, 1, 4'b1000, 1, 3'd3, 16'h3456, 4'b1000);
        vec[9]  = mk(4'b1010, 7, 4'b1000, 1, 3'd3, 16'h3456, 4'b1000);
        vec[10] = mk(4'b1010, 1, 4'b0010, 1, 3'd1, 16'h5678, 4'b0001);
        vec[11] = mk(4'b0000, 1, 4'b0000, 0, 3'd1, 16'h5678, 4'b0001);
        vec[12] = mk(4'b0100, 1, 4'b0100, 1, 3'd2, 16'h9012, 4'b0010);
        vec[13] = mk(4'b0000, 1, 4'b0000, 0, 3'd2, 16'h9012, 4'b0010);

        bus.req = '0; bus.src_digits = SRC_DIG; bus.src_dp = SRC_DP;
        @(posedge clk); #1;
        check_outputs("reset", 4'b0000, 1'b0, 3'd0, 16'h0000, 4'b0000);
        chk("reset.owner", 32'(bus.owner), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < vec[i].n; c++) begin
                bus.req = vec[i].req;
                @(posedge clk); #1;
                check_outputs($sformatf("vec%0d.%0d", i, c), vec[i].grant, vec[i].busy,
                              vec[i].owner, vec[i].dig, vec[i].dp);
            end
        end

        // Async reset while owning: outputs clear with no clock edge.
        bus.src_digits = {SRC_DIG[63:48], 16'h9959, SRC_DIG[31:0]};
        bus.req = 4'b0100;
        @(posedge clk); #1;
        check_outputs("pre_async", 4'b0100, 1'b1, 3'd2, 16'h9959, 4'b0010);
        #2 reset = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0000, 1'b0, 3'd0, 16'h0000, 4'b0000);
        chk("async_rst.owner", 32'(bus.owner), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.src_digits = SRC_DIG;
        bus.req = 4'b0100;

        // src2 owns, req[0] rises during its dwell.
        @(posedge clk); #1;
        check_outputs("prio.grant", 4'b0100, 1'b1, 3'd2, 16'h9012, 4'b0010);
        @(posedge clk); #1;
        bus.req = 4'b0101;
`ifdef DISPLAY_ARB_PRIORITY_EN
        @(posedge clk); #1;
        check_outputs("prio.preempt", 4'b0001, 1'b1, 3'd0, 16'h1234, 4'b0100);
`else
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check_outputs($sformatf("prio.dwell%0d", c), 4'b0100, 1'b1, 3'd2, 16'h9012, 4'b0010);
        end
        @(posedge clk); #1;
        check_outputs("prio.after_dwell", 4'b0001, 1'b1, 3'd0, 16'h1234, 4'b0100);
`endif

        // Randomized traffic against the model.
        reset = 1'b1;
        bus.req = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        r = '0; d = SRC_DIG; p = SRC_DP;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 2) r = 4'($urandom);
            if ($urandom_range(0, 9) < 3) d = {$urandom, $urandom};
            if ($urandom_range(0, 9) < 2) p = 16'($urandom);
            bus.req = r; bus.src_digits = d; bus.src_dp = p;
            model_step(r, d, p);
            @(posedge clk); #1;
            check_outputs($sformatf("rand%0d", c),
                          m_busy ? 4'(1 << m_owner) : 4'b0000, m_busy, 3'(m_owner), m_disp, m_dpv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_source_arbiter.md
# display_source_arbiter

Time-shares the single 4-digit seven-segment display among up to NUM_SRC producers (ADC readout, status codes, clock, etc.). Each producer raises a level request and presents four BCD digits plus decimal-point mask. The arbiter grants one source at a time under round-robin with a guaranteed minimum dwell, then drives the selected digits into seven_segment_display_subsystem (sec_dig1..min_dig2, decimal_point).

## Interface
- NUM_SRC, 4: number of requesters, 2..8
- DWELL_CYCLES, 100_000_000: minimum cycles a granted source holds the display when others are waiting; ≥2
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_SRC  level request per source; held high while the source wants the display
- src_digits  input  16*NUM_SRC  per source {min_dig2, min_dig1, sec_dig2, sec_dig1}, source i at bits [16i+15:16i]
- src_dp  input  4*NUM_SRC  per-source decimal_point mask, source i at [4i+3:4i]
- grant  output  NUM_SRC  one-hot grant, all-zero when idle
- owner  output  3  index of current owner (valid when busy)
- busy  output  1  display owned
- sec_dig1, sec_dig2, min_dig1, min_dig2  output  4 each  digits to the display subsystem
- decimal_point  output  4  dp mask to the display subsystem

## Operation
- States: IDLE, OWN.
- Reset (async): state IDLE, grant 0, owner 0, busy 0, all digits 0, decimal_point 0, dwell counter 0, round-robin pointer 0 (source 0 searched first).
- IDLE: if any req, grant the first requesting source searching from rr pointer upward with wrap; go to OWN; counter cleared.
- OWN: counter increments each cycle, saturating at DWELL_CYCLES-1; dwell_done = (counter == DWELL_CYCLES-1).
  - Owner drops req (any time, dwell or not): release. If another req is pending, grant it directly; else go to IDLE.
  - Owner still requesting, dwell_done, another source requesting: switch to the next requester after the owner (round-robin).
  - Owner still requesting, no other request: keep ownership indefinitely; counter stays saturated.
- On every grant, rr pointer = new owner + 1 (mod NUM_SRC); counter restarts at 0.
- While busy, digit/dp outputs follow the owner's src_digits/src_dp every cycle (live, registered).
- In IDLE, digit/dp outputs hold the last displayed values (no flicker to 0).
- req bits at index ≥ NUM_SRC ignored; grant is always one-hot or zero.

## Timing
- All outputs registered. Next-owner decision is combinational from req/state; grant, owner, busy and the digit mux all use that decision and update on the same edge.
- Grant latency: req rising in cycle N (IDLE) → grant/busy high and digits = that source's cycle-N data at cycle N+1.
- Data latency while owning: src_digits change in cycle N → outputs at N+1.
- Release latency: owner req low at cycle N → grant drops (or moves) at N+1; no gap cycle on handover.
- Simultaneous owner-release and dwell_done: treated as release.
- Reset asserted mid-ownership: outputs go to reset values immediately, independent of clk.

## Configuration
- DISPLAY_ARB_PRIORITY_EN defined: source 0 is urgent. If req[0] is high while another source owns, source 0 is granted on the next edge regardless of dwell. Source 0 also wins every IDLE/handover tie. Once source 0 owns, it is subject to the normal dwell rules.
- Not defined: pure round-robin; source 0 has no special treatment.

## Test plan
- NUM_SRC=4, DWELL_CYCLES=8. Reset, then req=0001 with src0 digits 1,2,3,4 and dp=0100 → cycle+1: grant=0001, owner=0, busy=1, {min_dig2..sec_dig1}=1,2,3,4, decimal_point=0100.
- Two requesters, owner keeps req: src0 owns, req=0011 from grant → grant stays 0001 for 8 cycles, then grant=0010 with no idle cycle; src1 holds 8 cycles, then returns to src0.
- Early release: src2 owns for 3 cycles and drops req, with src3 requesting → grant=1000 on the next edge; counter restarts.
- All release: owner drops req, no others → grant=0000, busy=0, digits hold last values; new req=0100 → grant=0100 next cycle.
- Async reset during OWN with digits 9,9,5,9 → outputs immediately 0, grant 0, busy 0, with no clock edge.
- DISPLAY_ARB_PRIORITY_EN: src2 owns at cycle 2 of dwell, req[0] rises → grant=0001 next edge. Without the macro, src2 keeps the grant until its 8-cycle dwell completes.
